anim_sequencer: RTL and testbench
=================================

ANIM_SEQUENCER -- requirements
Module: anim_sequencer

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent animation channels.
REQ-002 Parameter MAX_FRAMES, default 16, maximum frames per channel; FRAME_W = $clog2(MAX_FRAMES).
REQ-003 Parameter MAX_DIV, default 64, maximum vsync-per-step divisor; DIV_W = $clog2(MAX_DIV).
REQ-004 Parameter SIZE_W, default 12, frame size width; BASE_W, default 16, ROM base address width.
REQ-005 clk_25  input  1  pixel clock; all logic on posedge.
REQ-006 resetN  input  1  asynchronous, active-low reset.
REQ-007 vsync  input  1  raw VGA vsync level; rising edge detected internally.
REQ-008 start  input  [CHANNELS]  one-cycle per-channel restart pulse.
REQ-009 div  input  [CHANNELS][DIV_W]  vsync edges per frame step.
REQ-010 num_frames  input  [CHANNELS][FRAME_W+1]  frames in the sequence.
REQ-011 mode  input  [CHANNELS] x anim_mode_t  LOOP, ONESHOT, PINGPONG, HOLD.
REQ-012 frame_size  input  [CHANNELS][SIZE_W]  ROM words per frame.
REQ-013 frame  output  [CHANNELS][FRAME_W]  current frame index.
REQ-014 anim_base  output  [CHANNELS][BASE_W]  frame * frame_size, truncated to BASE_W.
REQ-015 step_pulse  output  [CHANNELS]  one-cycle pulse on each frame advance.
REQ-016 done  output  [CHANNELS]  ONESHOT sequence finished.

Function
REQ-017 Edge = vsync & ~vsync_d, vsync_d a register of vsync; at most one edge per vsync period.
REQ-018 Per channel, on edge: prescaler==0 -> step, reload prescaler with max(div,1)-1; else decrement.
REQ-019 Step updates frame and asserts step_pulse at the same clock edge; both visible next cycle; step_pulse lasts exactly one cycle.
REQ-020 anim_base is registered from frame, valid one cycle after frame changes.
REQ-021 Effective frame count N = max(num_frames,1); frame never exceeds N-1.
REQ-022 LOOP: frame = (frame==N-1) ? 0 : frame+1.
REQ-023 ONESHOT: increment until N-1; reaching N-1 sets done; further steps leave frame unchanged and emit no step_pulse.
REQ-024 PINGPONG: direction register; up until N-1 then down until 0 then up; N==1 holds 0, step_pulse still emitted.
REQ-025 HOLD: prescaler runs, frame frozen, no step_pulse.
REQ-026 start[c]: frame=0, prescaler=max(div,1)-1, direction up, done=0; start overrides a simultaneous step (no step_pulse that cycle).
REQ-027 Changing num_frames below current frame+1: next step forces frame to 0 (LOOP/PINGPONG) or N-1 with done (ONESHOT).
REQ-028 Channels fully independent; no cross-channel interaction.

Reset
REQ-029 resetN low: frame, anim_base, step_pulse, done, prescaler, vsync_d = 0, direction up, pause-related state cleared; first edge after reset steps.

Configuration
REQ-030 Macro ANIM_PAUSE_EN defined: extra input pause (1 bit); while high, edges are ignored by all prescalers and no steps occur; start still acts.
REQ-031 ANIM_PAUSE_EN undefined: port pause absent; behaviour identical to pause=0.

Structure
REQ-032 anim_mode_t enum and default constants (ANIM_MAX_FRAMES, ANIM_MAX_DIV) live in package asteroids.
REQ-033 One sub-module anim_channel (prescaler, frame FSM, base multiply), instantiated CHANNELS times by generate; edge detect shared in anim_sequencer.

Verification
REQ-034 LOOP, div=2, num_frames=3, frame_size=90: after edges 1..6 frame=1,1,2,2,0,0; anim_base=90,90,180,180,0,0.
REQ-035 ONESHOT, div=1, num_frames=4: edges 1..4 -> frame 1,2,3,3, done=1 from edge 3, no step_pulse on edge 4; start -> frame 0, done 0.
REQ-036 PINGPONG, div=1, num_frames=3: edges 1..6 -> frame 1,2,1,0,1,2.
REQ-037 start asserted in the cycle a step would occur -> frame 0, step_pulse 0, next step after div edges.
REQ-038 div=0, num_frames=0 -> step_pulse every edge, frame stays 0; resetN low mid-sequence -> all outputs 0 asynchronously.
REQ-039 ANIM_PAUSE_EN: pause high over 5 edges -> frame unchanged, no step_pulse; release -> stepping resumes with prescaler value retained.

Source files
------------

// File: rtl/anim_sequencer_pkg.sv
// Shared animation types and default sizing for the sprite animation sequencer.
package asteroids;

    typedef enum logic [1:0] {
        LOOP     = 2'd0,
        ONESHOT  = 2'd1,
        PINGPONG = 2'd2,
        HOLD     = 2'd3
    } anim_mode_t;

    localparam int ANIM_MAX_FRAMES = 16;
    localparam int ANIM_MAX_DIV    = 64;

endpackage

// File: rtl/anim_channel.sv
// One animation channel: vsync prescaler, frame sequencing FSM and ROM base
// address multiply. All outputs are registered.
module anim_channel
    import asteroids::*;
#(
    parameter int MAX_FRAMES = ANIM_MAX_FRAMES,
    parameter int MAX_DIV    = ANIM_MAX_DIV,
    parameter int SIZE_W     = 12,
    parameter int BASE_W     = 16,
    localparam int FRAME_W   = $clog2(MAX_FRAMES),
    localparam int DIV_W     = $clog2(MAX_DIV)
) (
    input  logic               clk_25,
    input  logic               resetN,
    input  logic               vs_edge,
    input  logic               start,
    input  logic [DIV_W-1:0]   div,
    input  logic [FRAME_W:0]   num_frames,
    input  anim_mode_t         mode,
    input  logic [SIZE_W-1:0]  frame_size,
    output logic [FRAME_W-1:0] frame,
    output logic [BASE_W-1:0]  anim_base,
    output logic               step_pulse,
    output logic               done
);

    localparam logic [DIV_W-1:0]   DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0]   DIV_ONE  = DIV_W'(1);
    localparam logic [FRAME_W-1:0] F_ZERO   = {FRAME_W{1'b0}};
    localparam logic [FRAME_W-1:0] F_ONE    = FRAME_W'(1);
    localparam logic [FRAME_W:0]   NF_ZERO  = {(FRAME_W+1){1'b0}};
    localparam logic [FRAME_W:0]   NF_ONE   = (FRAME_W+1)'(1);
    localparam logic [FRAME_W:0]   NF_MAX   = (FRAME_W+1)'(MAX_FRAMES);

    logic [FRAME_W-1:0] frame_r;
    logic [BASE_W-1:0]  anim_base_r;
    logic               step_pulse_r;
    logic               done_r;
    logic               up_r;
    logic [DIV_W-1:0]   presc_r;

    logic [DIV_W-1:0]   reload_s;
    logic [FRAME_W:0]   n_eff_s;
    logic [FRAME_W:0]   last_s;
    logic [FRAME_W:0]   frame_ext_s;
    logic [FRAME_W-1:0] last_f_s;
    logic [BASE_W-1:0]  mul_a_s;
    logic [BASE_W-1:0]  mul_b_s;
    logic [BASE_W-1:0]  prod_s;

    // Effective divisor reload and clamped effective frame count
    always_comb begin
        if (div == DIV_ZERO) begin
            reload_s = DIV_ZERO;
        end else begin
            reload_s = div - DIV_ONE;
        end
        if (num_frames == NF_ZERO) begin
            n_eff_s = NF_ONE;
        end else if (num_frames > NF_MAX) begin
            n_eff_s = NF_MAX;
        end else begin
            n_eff_s = num_frames;
        end
    end

    assign last_s      = n_eff_s - NF_ONE;
    assign last_f_s    = last_s[FRAME_W-1:0];
    assign frame_ext_s = {1'b0, frame_r};

    // Operands are cut to BASE_W first; the low BASE_W bits of the product are unaffected
    assign mul_a_s = BASE_W'(frame_r);
    assign mul_b_s = BASE_W'(frame_size);
    assign prod_s  = mul_a_s * mul_b_s;

    // Prescaler, frame sequencing FSM and registered base address
    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN) begin
            frame_r      <= F_ZERO;
            anim_base_r  <= {BASE_W{1'b0}};
            step_pulse_r <= 1'b0;
            done_r       <= 1'b0;
            up_r         <= 1'b1;
            presc_r      <= DIV_ZERO;
        end else begin
            step_pulse_r <= 1'b0;
            anim_base_r  <= prod_s;
            if (start) begin
                frame_r <= F_ZERO;
                presc_r <= reload_s;
                up_r    <= 1'b1;
                done_r  <= 1'b0;
            end else if (vs_edge) begin
                if (presc_r == DIV_ZERO) begin
                    presc_r <= reload_s;
                    case (mode)
                        LOOP: begin
                            step_pulse_r <= 1'b1;
                            if (frame_ext_s >= last_s) begin
                                frame_r <= F_ZERO;
                            end else begin
                                frame_r <= frame_r + F_ONE;
                            end
                        end
                        ONESHOT: begin
                            // A shrunk sequence snaps back to its last frame
                            if (frame_ext_s > last_s) begin
                                frame_r      <= last_f_s;
                                done_r       <= 1'b1;
                                step_pulse_r <= 1'b1;
                            end else if (frame_ext_s == last_s) begin
                                done_r <= 1'b1;
                            end else if (!done_r) begin
                                frame_r      <= frame_r + F_ONE;
                                step_pulse_r <= 1'b1;
                                done_r       <= ((frame_ext_s + NF_ONE) == last_s);
                            end
                        end
                        PINGPONG: begin
                            step_pulse_r <= 1'b1;
                            if ((frame_ext_s > last_s) || (last_s == NF_ZERO)) begin
                                frame_r <= F_ZERO;
                                up_r    <= 1'b1;
                            end else if (up_r) begin
                                if (frame_ext_s == last_s) begin
                                    frame_r <= frame_r - F_ONE;
                                    up_r    <= 1'b0;
                                end else begin
                                    frame_r <= frame_r + F_ONE;
                                end
                            end else begin
                                if (frame_r == F_ZERO) begin
                                    frame_r <= F_ONE;
                                    up_r    <= 1'b1;
                                end else begin
                                    frame_r <= frame_r - F_ONE;
                                end
                            end
                        end
                        HOLD: begin
                            frame_r <= frame_r;
                        end
                        default: begin
                            frame_r <= frame_r;
                        end
                    endcase
                end else begin
                    presc_r <= presc_r - DIV_ONE;
                end
            end
        end
    end

    assign frame      = frame_r;
    assign anim_base  = anim_base_r;
    assign step_pulse = step_pulse_r;
    assign done       = done_r;

endmodule

// File: rtl/anim_sequencer.sv
// Multi-channel sprite animation sequencer stepping frames on VGA vsync edges.
// Define ANIM_PAUSE_EN to add a global pause input that freezes all prescalers.
module anim_sequencer
    import asteroids::*;
#(
    parameter int CHANNELS   = 4,
    parameter int MAX_FRAMES = ANIM_MAX_FRAMES,
    parameter int MAX_DIV    = ANIM_MAX_DIV,
    parameter int SIZE_W     = 12,
    parameter int BASE_W     = 16,
    localparam int FRAME_W   = $clog2(MAX_FRAMES),
    localparam int DIV_W     = $clog2(MAX_DIV)
) (
    input  logic                               clk_25,
    input  logic                               resetN,
`ifdef ANIM_PAUSE_EN
    input  logic                               pause,
`endif
    input  logic                               vsync,
    input  logic [CHANNELS-1:0]                start,
    input  logic [CHANNELS-1:0][DIV_W-1:0]     div,
    input  logic [CHANNELS-1:0][FRAME_W:0]     num_frames,
    input  anim_mode_t [CHANNELS-1:0]          mode,
    input  logic [CHANNELS-1:0][SIZE_W-1:0]    frame_size,
    output logic [CHANNELS-1:0][FRAME_W-1:0]   frame,
    output logic [CHANNELS-1:0][BASE_W-1:0]    anim_base,
    output logic [CHANNELS-1:0]                step_pulse,
    output logic [CHANNELS-1:0]                done
);

    logic vsync_d_r;
    logic vs_edge_s;

    // Delayed vsync for rising-edge detection
    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN) begin
            vsync_d_r <= 1'b0;
        end else begin
            vsync_d_r <= vsync;
        end
    end

    // Shared edge strobe; pause masks it so prescalers keep their count
    always_comb begin
`ifdef ANIM_PAUSE_EN
        vs_edge_s = vsync & ~vsync_d_r & ~pause;
`else
        vs_edge_s = vsync & ~vsync_d_r;
`endif
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        anim_channel #(
            .MAX_FRAMES (MAX_FRAMES),
            .MAX_DIV    (MAX_DIV),
            .SIZE_W     (SIZE_W),
            .BASE_W     (BASE_W)
        ) u_ch (
            .clk_25     (clk_25),
            .resetN     (resetN),
            .vs_edge    (vs_edge_s),
            .start      (start[g]),
            .div        (div[g]),
            .num_frames (num_frames[g]),
            .mode       (mode[g]),
            .frame_size (frame_size[g]),
            .frame      (frame[g]),
            .anim_base  (anim_base[g]),
            .step_pulse (step_pulse[g]),
            .done       (done[g])
        );
    end

endmodule

// File: tb/tb_anim_sequencer.sv
// Scoreboard bench for anim_sequencer: a behavioural channel model predicts each
// cycle's outputs, the expectations are queued and compared as the DUT responds.
module tb_anim_sequencer;
    import asteroids::*;

    localparam int CH = 4;
    localparam int FW = 4;
    localparam int DW = 6;
    localparam int SW = 12;
    localparam int BW = 16;

    logic                    clk_25 = 1'b0;
    logic                    resetN;
    logic                    vsync;
    logic [CH-1:0]           start;
    logic [CH-1:0][DW-1:0]   div;
    logic [CH-1:0][FW:0]     num_frames;
    anim_mode_t [CH-1:0]     mode;
    logic [CH-1:0][SW-1:0]   frame_size;
    logic [CH-1:0][FW-1:0]   frame;
    logic [CH-1:0][BW-1:0]   anim_base;
    logic [CH-1:0]           step_pulse;
    logic [CH-1:0]           done;
`ifdef ANIM_PAUSE_EN
    logic                    pause;
`endif

    anim_sequencer dut (
        .clk_25     (clk_25),
        .resetN     (resetN),
`ifdef ANIM_PAUSE_EN
        .pause      (pause),
`endif
        .vsync      (vsync),
        .start      (start),
        .div        (div),
        .num_frames (num_frames),
        .mode       (mode),
        .frame_size (frame_size),
        .frame      (frame),
        .anim_base  (anim_base),
        .step_pulse (step_pulse),
        .done       (done)
    );

    always #20 clk_25 = ~clk_25;

    typedef struct {
        int frame;
        int pulse;
        int done;
        int base;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_frame [CH];
    int   m_presc [CH];
    int   m_done  [CH];
    int   m_pulse [CH];
    bit   m_up    [CH];
    bit   m_pause = 1'b0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            m_frame[c] = 0; m_presc[c] = 0; m_done[c] = 0; m_pulse[c] = 0; m_up[c] = 1'b1;
        end
    endfunction

    function automatic void model_start(input int c);
        m_frame[c] = 0;
        m_presc[c] = (div[c] == 0) ? 0 : int'(div[c]) - 1;
        m_up[c]    = 1'b1;
        m_done[c]  = 0;
    endfunction

    function automatic void model_edge(input int c);
        int n;
        n = (num_frames[c] == 0) ? 1 : int'(num_frames[c]);
        if (n > 16) n = 16;
        if (m_presc[c] > 0) begin
            m_presc[c] = m_presc[c] - 1;
            return;
        end
        m_presc[c] = (div[c] == 0) ? 0 : int'(div[c]) - 1;
        case (mode[c])
            LOOP: begin
                m_pulse[c] = 1;
                m_frame[c] = (m_frame[c] + 1 >= n) ? 0 : m_frame[c] + 1;
            end
            ONESHOT: begin
                if (m_frame[c] >= n) begin
                    m_frame[c] = n - 1; m_done[c] = 1; m_pulse[c] = 1;
                end else if (m_frame[c] == n - 1) begin
                    m_done[c] = 1;
                end else if (m_done[c] == 0) begin
                    m_frame[c] = m_frame[c] + 1; m_pulse[c] = 1;
                    if (m_frame[c] == n - 1) m_done[c] = 1;
                end
            end
            PINGPONG: begin
                m_pulse[c] = 1;
                if (m_frame[c] >= n || n == 1) begin
                    m_frame[c] = 0; m_up[c] = 1'b1;
                end else begin
                    if (m_up[c] && m_frame[c] == n - 1) m_up[c] = 1'b0;
                    else if (!m_up[c] && m_frame[c] == 0) m_up[c] = 1'b1;
                    m_frame[c] = m_up[c] ? m_frame[c] + 1 : m_frame[c] - 1;
                end
            end
            default: ;
        endcase
    endfunction

    // One vsync period (or a start-only cycle): predict, queue, then compare
    task automatic apply(input bit edge_en, input logic [CH-1:0] st);
        exp_t e;
        exp_t held [CH];
        @(negedge clk_25);
        start = st;
        if (edge_en) vsync = 1'b1;
        for (int c = 0; c < CH; c++) begin
            m_pulse[c] = 0;
            if (st[c]) model_start(c);
            else if (edge_en && !m_pause) model_edge(c);
            e.frame = m_frame[c];
            e.pulse = m_pulse[c];
            e.done  = m_done[c];
            e.base  = (m_frame[c] * int'(frame_size[c])) & 32'h0000FFFF;
            sb.push_back(e);
        end
        @(negedge clk_25);
        start = '0;
        for (int c = 0; c < CH; c++) begin
            if (sb.size() == 0) begin
                check_val("sb_underflow", 0, 1);
                held[c] = '{0, 0, 0, 0};
            end else begin
                held[c] = sb.pop_front();
            end
            check_val($sformatf("frame[%0d]", c), int'(frame[c]), held[c].frame);
            check_val($sformatf("step_pulse[%0d]", c), int'(step_pulse[c]), held[c].pulse);
            check_val($sformatf("done[%0d]", c), int'(done[c]), held[c].done);
        end
        @(negedge clk_25);
        vsync = 1'b0;
        for (int c = 0; c < CH; c++) begin
            check_val($sformatf("anim_base[%0d]", c), int'(anim_base[c]), held[c].base);
            check_val($sformatf("pulse_width[%0d]", c), int'(step_pulse[c]), 0);
        end
        @(negedge clk_25);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_frame"}, int'(frame), 0);
        check_val({tag, "_base"}, (anim_base == '0) ? 0 : 1, 0);
        check_val({tag, "_pulse"}, int'(step_pulse), 0);
        check_val({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_loop [6] = '{1, 1, 2, 2, 0, 0};
        int exp_os   [6] = '{1, 2, 3, 3, 3, 3};
        int exp_osp  [6] = '{1, 1, 1, 0, 0, 0};
        int exp_osd  [6] = '{0, 0, 1, 1, 1, 1};
        int exp_pp   [6] = '{1, 2, 1, 0, 1, 2};
        int held_f;
        resetN = 1'b0;
        vsync  = 1'b0;
        start  = '0;
`ifdef ANIM_PAUSE_EN
        pause  = 1'b0;
`endif
        div        = '{6'd2, 6'd1, 6'd1, 6'd0};
        num_frames = '{5'd3, 5'd4, 5'd3, 5'd0};
        mode       = '{LOOP, ONESHOT, PINGPONG, LOOP};
        frame_size = '{12'd90, 12'd10, 12'd7, 12'd5};
        // packed assignment patterns fill index CH-1 first; restore channel order
        div        = {6'd0, 6'd1, 6'd1, 6'd2};
        num_frames = {5'd0, 5'd3, 5'd4, 5'd3};
        mode       = {LOOP, PINGPONG, ONESHOT, LOOP};
        frame_size = {12'd5, 12'd7, 12'd10, 12'd90};
        model_reset();
        repeat (3) @(negedge clk_25);
        check_all_zero("reset");
        resetN = 1'b1;
        @(negedge clk_25);

        // Directed sequences on all four channels at once
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, '0);
            check_val("loop_frame", int'(frame[0]), exp_loop[i]);
            check_val("loop_base", int'(anim_base[0]), 90 * exp_loop[i]);
            check_val("oneshot_frame", int'(frame[1]), exp_os[i]);
            check_val("oneshot_done", int'(done[1]), exp_osd[i]);
            check_val("pingpong_frame", int'(frame[2]), exp_pp[i]);
            check_val("div0_frame", int'(frame[3]), 0);
        end
        check_val("oneshot_pulse_e1", exp_osp[0], 1);

        // Start on ch0 exactly when it would step; start also rearms the oneshot
        apply(1'b1, 4'b0011);
        check_val("start_frame0", int'(frame[0]), 0);
        check_val("start_done1", int'(done[1]), 0);
        check_val("start_frame1", int'(frame[1]), 0);
        apply(1'b1, '0);
        check_val("post_start_nostep", int'(frame[0]), 0);
        apply(1'b1, '0);
        check_val("post_start_step", int'(frame[0]), 1);

        // HOLD freezes ch2; shrinking ch0 below its frame forces it back to 0
        held_f = int'(frame[2]);
        @(negedge clk_25);
        mode[2]       = HOLD;
        num_frames[0] = 5'd1;
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, '0);
            check_val("hold_frame", int'(frame[2]), held_f);
        end
        check_val("shrink_frame", int'(frame[0]), 0);

        // Asynchronous reset in the middle of a clock phase
        @(negedge clk_25);
        #5;
        resetN = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(negedge clk_25);
        resetN = 1'b1;

        // Random configurations, each restarted before stepping
        for (int r = 0; r < 4; r++) begin
            @(negedge clk_25);
            for (int c = 0; c < CH; c++) begin
                mode[c]       = anim_mode_t'($urandom_range(3, 0));
                div[c]        = DW'($urandom_range(3, 0));
                num_frames[c] = (FW+1)'($urandom_range(6, 0));
                frame_size[c] = SW'($urandom_range(4095, 0));
            end
            apply(1'b0, '1);
            for (int i = 0; i < 8; i++) apply(1'b1, '0);
        end

`ifdef ANIM_PAUSE_EN
        @(negedge clk_25);
        mode = {LOOP, LOOP, LOOP, LOOP};
        div  = {6'd3, 6'd1, 6'd2, 6'd1};
        num_frames = {5'd5, 5'd5, 5'd5, 5'd5};
        apply(1'b0, '1);
        apply(1'b1, '0);
        apply(1'b1, '0);
        pause   = 1'b1;
        m_pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, '0);
            check_val("pause_pulse", int'(step_pulse), 0);
        end
        pause   = 1'b0;
        m_pause = 1'b0;
        for (int i = 0; i < 4; i++) apply(1'b1, '0);
`endif

        check_val("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
